// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-address-stack unit.
package pc_pkg;

  // Next-PC selection encodings carried on the sel port.
  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_RET    = 2'b11
  } pc_sel_e;

  // Low-address-bit mask that must be zero for an aligned instruction fetch.
  function automatic logic [63:0] align_mask(input int instr_bytes);
    return 64'(instr_bytes - 1);
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: top pointer plus valid-entry count.
// When full, a push advances the top pointer onto the oldest slot and
// overwrites it; push together with pop replaces the top entry in place.
// A pop on an empty stack is ignored, so push+pop on empty is a plain push.
module ras_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             top_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [CNT_W-1:0] count_q;
  logic             eff_pop;
  logic [PTR_W-1:0] wr_ptr;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign eff_pop  = pop & ~empty;
  assign count    = count_q;
  assign top_data = mem[top_q];

  // Write slot: the current top for a replace, the next slot for a push.
  always_comb begin
    wr_ptr = top_q + PTR_W'(1);
    if (eff_pop) begin
      wr_ptr = top_q;
    end
  end

  // Entry storage; contents beyond count are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Top pointer and count bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q   <= '1;
      count_q <= '0;
    end else if (push && eff_pop) begin
      top_q   <= top_q;
      count_q <= count_q;
    end else if (push) begin
      top_q <= top_q + PTR_W'(1);
      if (!full) begin
        count_q <= count_q + CNT_W'(1);
      end
    end else if (eff_pop) begin
      top_q   <= top_q - PTR_W'(1);
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with sequential/branch/jump/return selection and a
// return-address stack. State moves only on a rising edge with advance=1;
// the sticky flags can be cleared on any edge, and clearing wins over a set.
module pc_ras_unit
  import pc_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = 32'h0000_0000,
  parameter int              INSTR_BYTES = 4,
  parameter int              RAS_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         advance,
  input  logic [1:0]                   sel,
  input  logic [ADDR_W-1:0]            target,
  input  logic                         call,
  input  logic                         clear_flags,
  output logic [ADDR_W-1:0]            currentPointer,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow,
  output logic                         misaligned
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(align_mask(INSTR_BYTES));

  pc_sel_e           sel_mode;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] next_pc;
  logic [ADDR_W-1:0] top_data;
  logic              stk_full;
  logic              stk_empty;
  logic              is_ret;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_unf;
  logic              set_mis;
  logic              ovf_q;
  logic              unf_q;
  logic              mis_q;

  assign sel_mode = pc_sel_e'(sel);
  assign is_ret   = (sel_mode == PC_RET);
  assign seq_pc   = pc_q + ADDR_W'(INSTR_BYTES);

  // Stack control: a return with a call on a non-empty stack becomes a replace.
  assign do_push = advance & call;
  assign do_pop  = advance & is_ret & ~stk_empty;

  // Next-PC mux; a return on an empty stack falls through to sequential.
  always_comb begin
    next_pc = seq_pc;
    case (sel_mode)
      PC_SEQ:    next_pc = seq_pc;
      PC_BRANCH: next_pc = seq_pc + target;
      PC_JUMP:   next_pc = target;
      PC_RET:    if (!stk_empty) next_pc = top_data;
      default:   next_pc = seq_pc;
    endcase
  end

  assign set_ovf = do_push & stk_full & ~is_ret;
  assign set_unf = advance & is_ret & stk_empty;
  assign set_mis = advance & ((next_pc & ALIGN_MASK) != '0);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (seq_pc),
    .top_data  (top_data),
    .count     (ras_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_VEC;
    end else if (advance) begin
      pc_q <= next_pc;
    end
  end

  // Sticky flags; clear_flags has priority and ignores advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else if (clear_flags) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | set_ovf;
      unf_q <= unf_q | set_unf;
      mis_q <= mis_q | set_mis;
    end
  end

  assign currentPointer = pc_q;
  assign ras_overflow   = ovf_q;
  assign ras_underflow  = unf_q;
  assign misaligned     = mis_q;

endmodule
